// File: rtl/wb_hash_pkg.sv
// Shared definitions for the Wishbone hash-core wrapper.
//   state_e      : wrapper FSM states (IDLE, KICK, BUSY)
//   *_IDX        : word indices of the CTRL and STATUS registers
//   CTRL_* / STAT_* : bit positions inside CTRL and STATUS
//   block_base() / digest_base() : first word index of the block and digest windows
package wb_hash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  // Word index width: the index is taken from byte address bits [8:2].
  localparam int unsigned IDX_W = 7;

  localparam int unsigned CTRL_IDX   = 0;
  localparam int unsigned STATUS_IDX = 1;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_INIT  = 1;
  localparam int unsigned CTRL_IE    = 2;

  localparam int unsigned STAT_READY = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVR   = 3;

  function automatic int unsigned block_base();
    return 32'd2;
  endfunction

  function automatic int unsigned digest_base(input int unsigned block_words);
    return 32'd2 + block_words;
  endfunction

endpackage

// File: rtl/wb_hash_regfile.sv
// Message-block and digest storage for the hash wrapper.
//   clk, srst  : clock and synchronous active-high reset
//   wr_en_i    : write strobe for a block word (already qualified by the FSM)
//   wr_idx_i   : full word index of the write (block window is checked here)
//   wr_data_i, wr_sel_i : write data and byte enables
//   cap_en_i   : latch digest_i into the digest registers
//   rd_idx_i   : word index for the read mux
//   rd_data_o  : combinational read data for block/digest words (0 elsewhere)
//   blk_o      : flattened block, word i at [32i+31:32i]
module wb_hash_regfile
  import wb_hash_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS  = 16,
  parameter int unsigned DIGEST_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      wr_en_i,
  input  logic [IDX_W-1:0]          wr_idx_i,
  input  logic [31:0]               wr_data_i,
  input  logic [3:0]                wr_sel_i,
  input  logic                      cap_en_i,
  input  logic [32*DIGEST_WORDS-1:0] digest_i,
  input  logic [IDX_W-1:0]          rd_idx_i,
  output logic [31:0]               rd_data_o,
  output logic [32*BLOCK_WORDS-1:0] blk_o
);

  localparam int unsigned BLK_BASE = block_base();
  localparam int unsigned DIG_BASE = digest_base(BLOCK_WORDS);

  logic [32*DIGEST_WORDS-1:0] dig_flat;

  genvar gi;
  for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_blk
    logic [31:0] word_q, word_d;

    always_comb begin
      word_d = word_q;
      if (wr_en_i && (32'(wr_idx_i) == BLK_BASE + gi)) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_sel_i[b]) word_d[8*b +: 8] = wr_data_i[8*b +: 8];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (srst) word_q <= '0;
      else      word_q <= word_d;
    end

    assign blk_o[32*gi +: 32] = word_q;
  end

  for (gi = 0; gi < DIGEST_WORDS; gi++) begin : g_dig
    logic [31:0] word_q, word_d;

    always_comb begin
      word_d = word_q;
      if (cap_en_i) word_d = digest_i[32*gi +: 32];
    end

    always_ff @(posedge clk) begin
      if (srst) word_q <= '0;
      else      word_q <= word_d;
    end

    assign dig_flat[32*gi +: 32] = word_q;
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (32'(rd_idx_i) == BLK_BASE + 32'(i)) rd_data_o = blk_o[32*i +: 32];
    end
    for (int j = 0; j < DIGEST_WORDS; j++) begin
      if (32'(rd_idx_i) == DIG_BASE + 32'(j)) rd_data_o = dig_flat[32*j +: 32];
    end
  end

endmodule

// File: rtl/wb_hash_wrapper.sv
// Wishbone B4 classic slave in front of a block-hash core.
//   wb_*            : Wishbone slave port (32-bit data, registered ack/err/dat)
//   int_o           : level interrupt, DONE & IE
//   core_blk_o      : message block to the core, stable while a hash runs
//   core_init_o     : one-cycle "first block of message" pulse (with start)
//   core_start_o    : one-cycle "hash this block" pulse
//   core_ready_i    : core can accept a block
//   core_digest_i   : digest from the core, latched when core_digest_valid_i
//                     is seen in BUSY
module wb_hash_wrapper
  import wb_hash_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS  = 16,
  parameter int unsigned DIGEST_WORDS = 4,
  parameter int unsigned AW           = 32
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [AW-1:0]              wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       int_o,
  output logic [32*BLOCK_WORDS-1:0]  core_blk_o,
  output logic                       core_init_o,
  output logic                       core_start_o,
  input  logic                       core_ready_i,
  input  logic [32*DIGEST_WORDS-1:0] core_digest_i,
  input  logic                       core_digest_valid_i
);

  localparam int unsigned BLK_BASE = block_base();
  localparam int unsigned DIG_BASE = digest_base(BLOCK_WORDS);
  localparam int unsigned END_IDX  = DIG_BASE + DIGEST_WORDS;

  state_e      state_q, state_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic        ie_q, ie_d, done_q, done_d, ovr_q, ovr_d, init_q, init_d;
  logic        start_out_q, start_out_d, init_out_q, init_out_d;
  logic [31:0] dat_q, dat_d;

  logic [IDX_W-1:0] idx;
  logic        fire, legal, wr_acc, rd_acc;
  logic        is_ctrl, is_status, is_blk, is_dig;
  logic        ready, blk_wr, capture;
  logic [31:0] rf_rd_data, status_v;
  logic        unused_adr;

  assign idx        = wb_adr_i[8:2];
  assign unused_adr = ^wb_adr_i;

  // Suppressing a new transfer while a termination is out gives one
  // termination every two cycles on a held strobe.
  assign fire      = wb_cyc_i & wb_stb_i & ~(ack_q | err_q);
  assign is_ctrl   = (32'(idx) == CTRL_IDX);
  assign is_status = (32'(idx) == STATUS_IDX);
  assign is_blk    = (32'(idx) >= BLK_BASE) && (32'(idx) < DIG_BASE);
  assign is_dig    = (32'(idx) >= DIG_BASE) && (32'(idx) < END_IDX);
  assign legal     = is_ctrl | is_status | is_blk | (is_dig & ~wb_we_i);
  assign wr_acc    = fire & legal & wb_we_i;
  assign rd_acc    = fire & legal & ~wb_we_i;
  assign ready     = core_ready_i & (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    ie_d     = ie_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    init_d   = init_q;
    dat_d    = dat_q;
    blk_wr   = 1'b0;
    capture  = 1'b0;
    status_v = '0;
    ack_d    = fire & legal;
    err_d    = fire & ~legal;

    case (state_q)
      ST_KICK: state_d = ST_BUSY;
      ST_BUSY: begin
        if (core_digest_valid_i) begin
          state_d = ST_IDLE;
          capture = 1'b1;
        end
      end
      default: ;
    endcase

    if (wr_acc) begin
      if (is_ctrl) begin
        ie_d = wb_dat_i[CTRL_IE];
        if (wb_dat_i[CTRL_START]) begin
          if (ready) begin
            state_d = ST_KICK;
            init_d  = wb_dat_i[CTRL_INIT];
            done_d  = 1'b0;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      if (is_status) begin
        if (wb_dat_i[STAT_DONE]) done_d = 1'b0;
        if (wb_dat_i[STAT_OVR])  ovr_d  = 1'b0;
      end
      // The block is frozen outside IDLE so the core sees a stable input.
      if (is_blk) begin
        if (state_q == ST_IDLE) blk_wr = 1'b1;
        else                    ovr_d  = 1'b1;
      end
    end

    // Applied after the clear so a same-edge capture leaves DONE set.
    if (capture) done_d = 1'b1;

    // STATUS reflects the post-edge view, so a read sampled on the capture
    // edge already reports DONE.
    status_v[STAT_READY] = core_ready_i & (state_d == ST_IDLE);
    status_v[STAT_DONE]  = done_d;
    status_v[STAT_BUSY]  = (state_d == ST_BUSY);
    status_v[STAT_OVR]   = ovr_d;

    if (rd_acc) begin
      if (is_ctrl)        dat_d = {29'b0, ie_q, 2'b0};
      else if (is_status) dat_d = status_v;
      else                dat_d = rf_rd_data;
    end
  end

  // Core strobes are registered from KICK, landing one cycle after the ack.
  assign start_out_d = (state_q == ST_KICK);
  assign init_out_d  = (state_q == ST_KICK) & init_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      ie_q        <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      init_q      <= 1'b0;
      start_out_q <= 1'b0;
      init_out_q  <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      ie_q        <= ie_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      init_q      <= init_d;
      start_out_q <= start_out_d;
      init_out_q  <= init_out_d;
      dat_q       <= dat_d;
    end
  end

  wb_hash_regfile #(
    .BLOCK_WORDS  (BLOCK_WORDS),
    .DIGEST_WORDS (DIGEST_WORDS)
  ) u_regfile (
    .clk       (wb_clk_i),
    .srst      (wb_rst_i),
    .wr_en_i   (blk_wr),
    .wr_idx_i  (idx),
    .wr_data_i (wb_dat_i),
    .wr_sel_i  (wb_sel_i),
    .cap_en_i  (capture),
    .digest_i  (core_digest_i),
    .rd_idx_i  (idx),
    .rd_data_o (rf_rd_data),
    .blk_o     (core_blk_o)
  );

  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign wb_dat_o     = dat_q;
  assign int_o        = done_q & ie_q;
  assign core_start_o = start_out_q;
  assign core_init_o  = init_out_q;

endmodule

// File: tb/tb_wb_hash_wrapper.sv
// Self-checking bench for wb_hash_wrapper: bus transfers push their expected
// termination/read data onto a scoreboard queue, popped when the DUT terminates.
module tb_wb_hash_wrapper;

  localparam int unsigned BW = 16;
  localparam int unsigned DW = 4;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [31:0]       wb_adr_i;
  logic [31:0]       wb_dat_i;
  logic [3:0]        wb_sel_i;
  logic              wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack_o, wb_err_o, int_o;
  logic [32*BW-1:0]  core_blk_o;
  logic              core_init_o, core_start_o;
  logic              core_ready_i;
  logic [32*DW-1:0]  core_digest_i;
  logic              core_digest_valid_i;

  wb_hash_wrapper #(.BLOCK_WORDS(BW), .DIGEST_WORDS(DW), .AW(32)) dut (
    .wb_clk_i            (wb_clk_i),
    .wb_rst_i            (wb_rst_i),
    .wb_adr_i            (wb_adr_i),
    .wb_dat_i            (wb_dat_i),
    .wb_sel_i            (wb_sel_i),
    .wb_cyc_i            (wb_cyc_i),
    .wb_stb_i            (wb_stb_i),
    .wb_we_i             (wb_we_i),
    .wb_dat_o            (wb_dat_o),
    .wb_ack_o            (wb_ack_o),
    .wb_err_o            (wb_err_o),
    .int_o               (int_o),
    .core_blk_o          (core_blk_o),
    .core_init_o         (core_init_o),
    .core_start_o        (core_start_o),
    .core_ready_i        (core_ready_i),
    .core_digest_i       (core_digest_i),
    .core_digest_valid_i (core_digest_valid_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    string       tag;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic bus(input string tag, input bit we, input int idx, input logic [31:0] wdat,
                     input logic [3:0] sel, input bit exp_err, input bit chk_rd,
                     input logic [31:0] exp_rd, input bit with_dv);
    exp_t e;
    int   n;
    e.tag = tag; e.exp_err = exp_err; e.chk_rd = chk_rd; e.exp_rd = exp_rd;
    exp_q.push_back(e);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = 32'(idx) << 2; wb_dat_i = wdat; wb_sel_i = sel;
    if (with_dv) core_digest_valid_i = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1;
      if (with_dv) core_digest_valid_i = 1'b0;
      n++;
    end while (!(wb_ack_o | wb_err_o) && n < 16);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    e = exp_q.pop_front();
    if (!(wb_ack_o | wb_err_o)) begin
      check({e.tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({e.tag, ".err"}, 32'(wb_err_o), 32'(e.exp_err));
      check({e.tag, ".ack"}, 32'(wb_ack_o), 32'(!e.exp_err));
      if (e.chk_rd) check({e.tag, ".dat"}, wb_dat_o, e.exp_rd);
    end
    $display("xfer %s we=%0d idx=%0d ack=%0d err=%0d dat=0x%08h", e.tag, we, idx,
             wb_ack_o, wb_err_o, wb_dat_o);
  endtask

  task automatic rd(input string tag, input int idx, input logic [31:0] exp);
    bus(tag, 1'b0, idx, 32'd0, 4'h0, 1'b0, 1'b1, exp, 1'b0);
  endtask

  task automatic wr(input string tag, input int idx, input logic [31:0] d, input logic [3:0] sel);
    bus(tag, 1'b1, idx, d, sel, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic bad(input string tag, input bit we, input int idx);
    bus(tag, we, idx, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic pulse_dv();
    @(posedge wb_clk_i); #1;
    core_digest_valid_i = 1'b1;
    @(posedge wb_clk_i); #1;
    core_digest_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack, n_err;
    wb_rst_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    core_ready_i = 1'b1; core_digest_i = '0; core_digest_valid_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Reset state
    check("rst.ack", 32'(wb_ack_o), 32'd0);
    check("rst.err", 32'(wb_err_o), 32'd0);
    check("rst.dat", wb_dat_o, 32'd0);
    check("rst.int", 32'(int_o), 32'd0);
    check("rst.blk", 32'(|core_blk_o), 32'd0);
    check("rst.init", 32'(core_init_o), 32'd0);
    check("rst.start", 32'(core_start_o), 32'd0);
    rd("rst.status", 1, 32'h1);

    // Held strobe: one termination every two cycles
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'd1 << 2;
    n_ack = 0; n_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      n_ack += int'(wb_ack_o);
      n_err += int'(wb_err_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("held.acks", 32'(n_ack), 32'd2);
    check("held.errs", 32'(n_err), 32'd0);
    wait_cycles(1);

    // Block data, byte masks, window edges
    wr("blk2.wr", 2, 32'hDEAD_BEEF, 4'b0011);
    rd("blk2.rd", 2, 32'h0000_BEEF);
    check("blk2.port", core_blk_o[31:0], 32'h0000_BEEF);
    wr("blk3.wr", 3, 32'h1234_5678, 4'hF);
    wr("blk3.wrhi", 3, 32'hAABB_CCDD, 4'b1100);
    rd("blk3.rd", 3, 32'hAABB_5678);
    wr("blk17.wr", 17, 32'hCAFE_F00D, 4'hF);
    rd("blk17.rd", 17, 32'hCAFE_F00D);
    check("blk17.port", core_blk_o[32*15 +: 32], 32'hCAFE_F00D);
    rd("dig0.rst", 18, 32'h0);
    bad("dig0.wr", 1'b1, 18);
    bad("idx7f.wr", 1'b1, 127);
    bad("idx7f.rd", 1'b0, 127);
    bad("idx22.rd", 1'b0, 22);
    rd("blk17.keep", 17, 32'hCAFE_F00D);

    // First hash: START+INIT+IE
    rd("ctrl.rst", 0, 32'h0);
    wr("ctrl.go", 0, 32'h7, 4'hF);
    check("kick.start_ack", 32'(core_start_o), 32'd0);
    wait_cycles(1);
    check("kick.start", 32'(core_start_o), 32'd1);
    check("kick.init", 32'(core_init_o), 32'd1);
    wait_cycles(1);
    check("kick.start_end", 32'(core_start_o), 32'd0);
    check("kick.init_end", 32'(core_init_o), 32'd0);
    rd("ctrl.ie", 0, 32'h4);
    rd("busy.status", 1, 32'h4);
    core_digest_i = '0;
    core_digest_i[31:0]  = 32'h0123_4567;
    core_digest_i[63:32] = 32'h89AB_CDEF;
    wait_cycles(64);
    pulse_dv();
    check("done.int", 32'(int_o), 32'd1);
    rd("done.status", 1, 32'h3);
    rd("dig0.rd", 18, 32'h0123_4567);
    rd("dig1.rd", 19, 32'h89AB_CDEF);

    // Second hash: overrun during BUSY, then clear racing capture
    wr("ctrl.go2", 0, 32'h5, 4'hF);
    wait_cycles(1);
    check("kick2.start", 32'(core_start_o), 32'd1);
    check("kick2.init", 32'(core_init_o), 32'd0);
    rd("busy2.status", 1, 32'h4);
    check("busy2.int", 32'(int_o), 32'd0);
    wr("busy2.blkwr", 2, 32'h1, 4'hF);
    check("busy2.blk", core_blk_o[31:0], 32'h0000_BEEF);
    wr("busy2.start", 0, 32'h5, 4'hF);
    rd("ovr.status", 1, 32'hC);
    wr("ovr.clr", 1, 32'hA, 4'hF);
    rd("ovr.cleared", 1, 32'h4);
    core_digest_i[31:0] = 32'h55AA_55AA;
    bus("race.clr", 1'b1, 1, 32'h2, 4'hF, 1'b0, 1'b0, 32'd0, 1'b1);
    rd("race.status", 1, 32'h3);
    check("race.int", 32'(int_o), 32'd1);
    rd("race.dig0", 18, 32'h55AA_55AA);

    // Third hash: reset mid-BUSY, late digest ignored
    wr("ctrl.go3", 0, 32'h5, 4'hF);
    wait_cycles(3);
    rd("busy3.status", 1, 32'h4);
    wb_rst_i = 1'b1;
    wait_cycles(1);
    wb_rst_i = 1'b0;
    check("rst3.int", 32'(int_o), 32'd0);
    check("rst3.blk", 32'(|core_blk_o), 32'd0);
    rd("rst3.status", 1, 32'h1);
    pulse_dv();
    rd("rst3.late", 1, 32'h1);
    rd("rst3.dig0", 18, 32'h0);

    // START while the core is not ready: OVR, stays idle
    core_ready_i = 1'b0;
    wr("nr.start", 0, 32'h1, 4'hF);
    wait_cycles(1);
    check("nr.nostart", 32'(core_start_o), 32'd0);
    rd("nr.status", 1, 32'h8);
    core_ready_i = 1'b1;
    wr("nr.clr", 1, 32'h8, 4'hF);
    rd("nr.cleared", 1, 32'h1);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
